// File: rtl/lane_game_pkg.sv
// Shared definitions for the lane runner game controller:
// FSM state codes, spawn threshold default and RNG seed.
package lane_game_pkg;

  localparam logic [3:0] S_LOGGEDOUT = 4'd0;
  localparam logic [3:0] S_WAIT      = 4'd1;
  localparam logic [3:0] S_START     = 4'd2;
  localparam logic [3:0] S_PLAY      = 4'd3;
  localparam logic [3:0] S_MOVE      = 4'd4;
  localparam logic [3:0] S_END       = 4'd5;
  localparam logic [3:0] S_PAUSE     = 4'd6;

  localparam logic [15:0] THRESH_INIT_DFLT = 16'h8080;
  localparam logic [15:0] LFSR_SEED        = 16'hACE1;

endpackage

// File: rtl/LFSR_16b.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
// Seeded by reset, then advances every clock.
module LFSR_16b
  import lane_game_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  output logic [15:0] rnd_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  assign fb = lfsr_q[15] ^ lfsr_q[13]
            ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d = {lfsr_q[14:0], fb};
  assign rnd_o  = lfsr_q;

  always_ff @(posedge Clk) begin
    if (!Rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/game_tick_timer.sv
// Divides the timebase strobe into game ticks; the period
// shrinks by one per spawning tick down to a floor.
module game_tick_timer #(
  parameter int TICK_W    = 10,
  parameter int TICK_INIT = 300,
  parameter int TICK_MIN  = 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic init_i,
  input  logic run_i,
  input  logic tick_en_i,
  input  logic dec_i,
  output logic tick_ev_o,
  output logic tick_o
);

  logic [TICK_W-1:0] count_q, count_d;
  logic [TICK_W-1:0] period_q, period_d;
  logic              tick_q;

  // Combinational event so the map updates on the same edge
  assign tick_ev_o = run_i & tick_en_i
                   & (count_q >= period_q - TICK_W'(1));
  assign tick_o    = tick_q;

  always_comb begin
    count_d  = count_q;
    period_d = period_q;
    if (init_i) begin
      count_d  = '0;
      period_d = TICK_W'(TICK_INIT);
    end else if (run_i && tick_en_i) begin
      if (tick_ev_o) begin
        count_d = '0;
        if (dec_i && period_q > TICK_W'(TICK_MIN))
          period_d = period_q - TICK_W'(1);
      end else begin
        count_d = count_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      count_q  <= '0;
      period_q <= TICK_W'(TICK_INIT);
      tick_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
      tick_q   <= tick_ev_o & ~init_i;
    end
  end

endmodule

// File: rtl/lane_game_ctrl.sv
// Multi-lane runner controller: FSM, lane map, spawner,
// score and high score.
module lane_game_ctrl
  import lane_game_pkg::*;
#(
  parameter int          LANES       = 2,
  parameter int          SURF_W      = 6,
  parameter int          PLAYER_COL  = 4,
  parameter int          SCORE_W     = 14,
  parameter int          SCORE_MAX   = 9999,
  parameter int          TICK_W      = 10,
  parameter int          TICK_INIT   = 300,
  parameter int          TICK_MIN    = 1,
  parameter logic [15:0] THRESH_INIT = THRESH_INIT_DFLT
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      LoggedIn,
  input  logic                      TickEn,
  input  logic                      BtnUp,
  input  logic                      BtnDown,
  input  logic                      BtnPause,
  output logic [LANES*SURF_W-1:0]   LaneMap,
  output logic [$clog2(LANES)-1:0]  PlayerLane,
  output logic                      GameTick,
  output logic [3:0]                GameState,
  output logic [SCORE_W-1:0]        GameScore,
  output logic [SCORE_W-1:0]        HighScore
);

  localparam int LW = $clog2(LANES);
  localparam int MW = LANES * SURF_W;

  logic [3:0]         state_q, state_d;
  logic [MW-1:0]      map_q, map_d;
  logic [LW-1:0]      lane_q, lane_d;
  logic               dir_q, dir_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] hs_q, hs_d;
  logic [15:0]        thresh_q, thresh_d;

  logic [15:0]        rnd;
  logic               clr, run, init;
  logic               tick_ev, spawn;
  logic [LW-1:0]      sel, tgt;
  logic               edge_hit;
  logic [MW-1:0]      shifted;
  logic [LANES-1:0]   col_new, col_cur;
  logic [SCORE_W-1:0] score_inc;

  LFSR_16b u_lfsr (
    .Clk   (Clk),
    .Rst   (Rst),
    .rnd_o (rnd)
  );

  game_tick_timer #(
    .TICK_W    (TICK_W),
    .TICK_INIT (TICK_INIT),
    .TICK_MIN  (TICK_MIN)
  ) u_timer (
    .Clk       (Clk),
    .Rst       (Rst),
    .init_i    (init),
    .run_i     (run),
    .tick_en_i (TickEn),
    .dec_i     (spawn),
    .tick_ev_o (tick_ev),
    .tick_o    (GameTick)
  );

  // Logout and illegal codes both land in LOGGEDOUT cleared
  assign clr  = ~LoggedIn | (state_q > S_PAUSE);
  assign run  = LoggedIn & (state_q == S_PLAY);
  assign init = clr | (state_q == S_START);

  assign spawn = rnd > thresh_q;
  assign sel   = LW'(32'(rnd[7:0]) % LANES);

  assign score_inc =
    (score_q >= SCORE_W'(SCORE_MAX)) ?
    score_q : score_q + SCORE_W'(1);

  assign tgt = dir_q ? lane_q + LW'(1)
                     : lane_q - LW'(1);
  assign edge_hit =
    dir_q ? (lane_q == LW'(LANES - 1))
          : (lane_q == '0);

  always_comb begin
    shifted = '0;
    col_new = '0;
    col_cur = '0;
    for (int l = 0; l < LANES; l++) begin
      shifted[l*SURF_W +: SURF_W] =
        {map_q[l*SURF_W +: SURF_W-1],
         ~spawn | (sel != LW'(l))};
      col_new[l] = shifted[l*SURF_W + PLAYER_COL];
      col_cur[l] = map_q[l*SURF_W + PLAYER_COL];
    end
  end

  always_comb begin
    state_d  = state_q;
    map_d    = map_q;
    lane_d   = lane_q;
    dir_d    = dir_q;
    score_d  = score_q;
    hs_d     = hs_q;
    thresh_d = thresh_q;
    if (clr) begin
      state_d  = S_LOGGEDOUT;
      map_d    = '1;
      lane_d   = '0;
      score_d  = '0;
      hs_d     = '0;
      thresh_d = THRESH_INIT;
    end else begin
      unique case (state_q)
        S_LOGGEDOUT: state_d = S_WAIT;
        S_WAIT:
          if (BtnUp | BtnDown) state_d = S_START;
        S_START: begin
          map_d    = '1;
          lane_d   = '0;
          score_d  = '0;
          thresh_d = THRESH_INIT;
          state_d  = S_PLAY;
        end
        S_PLAY: begin
          if (tick_ev) begin
            map_d    = shifted;
            score_d  = score_inc;
            thresh_d = spawn ? THRESH_INIT :
                       (thresh_q == '0) ? '0 :
                       thresh_q - 16'd1;
          end
          // Tick wins: a collision ends the game first
          if (tick_ev && !col_new[lane_q]) begin
            state_d = S_END;
          end else if (BtnPause) begin
            state_d = S_PAUSE;
          end else if (BtnUp ^ BtnDown) begin
            state_d = S_MOVE;
            dir_d   = BtnUp;
          end
        end
        S_MOVE: begin
          if (edge_hit) begin
            state_d = S_PLAY;
          end else if (!col_cur[tgt]) begin
            state_d = S_END;
          end else begin
            lane_d  = tgt;
            state_d = S_PLAY;
          end
        end
        S_END:
          if (BtnUp | BtnDown) state_d = S_WAIT;
        S_PAUSE:
          if (BtnPause) state_d = S_PLAY;
        default: state_d = S_LOGGEDOUT;
      endcase
      if (state_d == S_END && state_q != S_END
          && score_d > hs_q)
        hs_d = score_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= S_LOGGEDOUT;
      map_q    <= '1;
      lane_q   <= '0;
      dir_q    <= 1'b0;
      score_q  <= '0;
      hs_q     <= '0;
      thresh_q <= THRESH_INIT;
    end else begin
      state_q  <= state_d;
      map_q    <= map_d;
      lane_q   <= lane_d;
      dir_q    <= dir_d;
      score_q  <= score_d;
      hs_q     <= hs_d;
      thresh_q <= thresh_d;
    end
  end

  assign LaneMap    = map_q;
  assign PlayerLane = lane_q;
  assign GameState  = state_q;
  assign GameScore  = score_q;
  assign HighScore  = hs_q;

endmodule

// File: tb/tb_lane_game_ctrl.sv
// Random-stimulus bench for lane_game_ctrl against a
// lane/column array model of the game rules.
module tb_lane_game_ctrl;

  localparam int LANES  = 3;
  localparam int SURF_W = 6;
  localparam int PCOL   = 4;
  localparam int SW     = 14;
  localparam int SMAX   = 12;
  localparam int TW     = 10;
  localparam int TINIT  = 3;
  localparam int TMIN   = 1;
  localparam bit [15:0] THR = 16'h8080;
  localparam int LW     = $clog2(LANES);

  localparam int ST_OUT   = 0;
  localparam int ST_WAIT  = 1;
  localparam int ST_START = 2;
  localparam int ST_PLAY  = 3;
  localparam int ST_MOVE  = 4;
  localparam int ST_END   = 5;
  localparam int ST_PAUSE = 6;

  logic clk = 1'b0;
  logic rst, li, te, up, dn, ps;
  logic [LANES*SURF_W-1:0] lane_map;
  logic [LW-1:0]           p_lane;
  logic                    g_tick;
  logic [3:0]              g_state;
  logic [SW-1:0]           g_score, h_score;

  always #5 clk = ~clk;

  lane_game_ctrl #(
    .LANES(LANES), .SURF_W(SURF_W),
    .PLAYER_COL(PCOL), .SCORE_W(SW),
    .SCORE_MAX(SMAX), .TICK_W(TW),
    .TICK_INIT(TINIT), .TICK_MIN(TMIN),
    .THRESH_INIT(THR)
  ) dut (
    .Clk(clk), .Rst(rst), .LoggedIn(li),
    .TickEn(te), .BtnUp(up), .BtnDown(dn),
    .BtnPause(ps), .LaneMap(lane_map),
    .PlayerLane(p_lane), .GameTick(g_tick),
    .GameState(g_state), .GameScore(g_score),
    .HighScore(h_score)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_sat = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  int        m_state, m_lane, m_score, m_hs;
  int        m_period, m_cnt;
  bit        m_up, m_tick;
  bit [15:0] m_thresh, m_lfsr;
  bit        m_map[LANES][SURF_W];

  function automatic bit [15:0] lfsr_adv(bit [15:0] x);
    bit fb;
    fb = x[15] ^ x[13] ^ x[12] ^ x[10];
    return {x[14:0], fb};
  endfunction

  function automatic logic [31:0] map_word();
    logic [31:0] v = '0;
    for (int l = 0; l < LANES; l++)
      for (int c = 0; c < SURF_W; c++)
        v[l*SURF_W + c] = m_map[l][c];
    return v;
  endfunction

  task automatic new_game();
    foreach (m_map[l, c]) m_map[l][c] = 1'b1;
    m_lane = 0; m_score = 0;
    m_period = TINIT; m_cnt = 0; m_thresh = THR;
  endtask

  task automatic to_end();
    m_state = ST_END;
    if (m_score > m_hs) m_hs = m_score;
  endtask

  task automatic game_tick();
    bit spawn;
    int pick;
    spawn = m_lfsr > m_thresh;
    pick  = int'(m_lfsr[7:0]) % LANES;
    for (int l = 0; l < LANES; l++) begin
      for (int c = SURF_W - 1; c > 0; c--)
        m_map[l][c] = m_map[l][c-1];
      m_map[l][0] = !(spawn && l == pick);
    end
    m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
    if (m_score == SMAX) n_sat++;
    if (spawn) begin
      m_thresh = THR;
      if (m_period > TMIN) m_period--;
    end else if (m_thresh != 0) begin
      m_thresh--;
    end
  endtask

  task automatic model_step();
    bit        nt = 1'b0;
    bit [15:0] old = m_lfsr;
    int        t;
    if (!rst) begin
      new_game();
      m_state = ST_OUT; m_hs = 0; m_up = 0;
      m_tick = 0; m_lfsr = 16'hACE1;
      return;
    end
    if (!li) begin
      new_game();
      m_state = ST_OUT; m_hs = 0;
    end else begin
      case (m_state)
        ST_OUT:  m_state = ST_WAIT;
        ST_WAIT: if (up || dn) m_state = ST_START;
        ST_START: begin
          new_game();
          m_state = ST_PLAY;
        end
        ST_PLAY: begin
          if (te) begin
            if (m_cnt == m_period - 1) begin
              m_cnt = 0; nt = 1'b1;
              game_tick();
            end else begin
              m_cnt++;
            end
          end
          if (nt && !m_map[m_lane][PCOL]) to_end();
          else if (ps) m_state = ST_PAUSE;
          else if (up != dn) begin
            m_up = up; m_state = ST_MOVE;
          end
        end
        ST_MOVE: begin
          t = m_up ? m_lane + 1 : m_lane - 1;
          if (t < 0 || t >= LANES) m_state = ST_PLAY;
          else if (!m_map[t][PCOL]) to_end();
          else begin
            m_lane = t; m_state = ST_PLAY;
          end
        end
        ST_END:   if (up || dn) m_state = ST_WAIT;
        ST_PAUSE: if (ps) m_state = ST_PLAY;
        default:  m_state = ST_OUT;
      endcase
    end
    m_tick = nt;
    m_lfsr = lfsr_adv(old);
  endtask

  task automatic compare_all();
    check("state", 32'(g_state), m_state);
    check("map", 32'(lane_map), map_word());
    check("lane", 32'(p_lane), m_lane);
    check("tick", 32'(g_tick), 32'(m_tick));
    check("score", 32'(g_score), m_score);
    check("high", 32'(h_score), m_hs);
  endtask

  initial begin
    rst = 1'b0; li = 1'b0; te = 1'b0;
    up = 1'b0; dn = 1'b0; ps = 1'b0;
    model_step();
    for (int cyc = 0; cyc < 9000; cyc++) begin
      @(negedge clk);
      compare_all();
      rst = (cyc < 2) ? 1'b0 :
            ($urandom_range(0, 2499) != 0);
      if (cyc < 4) li = 1'b0;
      else if (cyc < 8) li = 1'b1;
      else if (li) li = ($urandom_range(0, 399) != 0);
      else li = ($urandom_range(0, 3) == 0);
      te = $urandom_range(0, 1) == 0;
      up = $urandom_range(0, 6) == 0;
      dn = $urandom_range(0, 6) == 0;
      ps = $urandom_range(0, 39) == 0;
      model_step();
    end
    @(negedge clk);
    compare_all();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
